sample_decimator: RTL and testbench
===================================

SAMPLE_DECIMATOR -- requirements
Module: sample_decimator

Interface
REQ-001 SHALL have parameter BITWIDTH, default 32, sample width; two's-complement signed.
REQ-002 SHALL have parameter MAX_DEC_LOG2, default 8, maximum log2 decimation ratio.
REQ-003 SHALL have parameter DEC_WIDTH, default 4, width of the dec_log2 port.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have port n_RST  input  1  asynchronous active-low reset.
REQ-006 SHALL have port sig_in  input  BITWIDTH  filtered sample from the upstream filter stage.
REQ-007 SHALL have port in_valid  input  1  sig_in qualifier; may be tied high.
REQ-008 SHALL have port dec_log2  input  DEC_WIDTH  log2 of decimation ratio N.
REQ-009 SHALL have port restart  input  1  synchronous abort of the partial frame.
REQ-010 SHALL have port out_data  output  BITWIDTH  decimated sample.
REQ-011 SHALL have port out_valid  output  1  out_data holds a result.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port overrun  output  1  sticky result-drop flag.
REQ-014 SHALL have port clr_overrun  input  1  synchronous clear of overrun.

Function
REQ-015 SHALL accumulate N = 2^min(dec_log2, MAX_DEC_LOG2) valid samples per frame, sign-extended into a BITWIDTH+MAX_DEC_LOG2 accumulator.
REQ-016 SHALL latch the clamped dec_log2 on the first valid sample of each frame; a mid-frame change SHALL apply only from the next frame.
REQ-017 SHALL compute result = (acc + final sample) arithmetic-shifted right by the latched dec_log2, truncated to BITWIDTH.
REQ-018 SHALL push the result into a 2-entry output FIFO; out_valid SHALL rise on the cycle after the frame's final sample is accepted.
REQ-019 SHALL transfer a result when out_valid and out_ready are both high; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, when the FIFO is full and no pop happens that cycle, drop the new result and set overrun; a simultaneous pop and push with a full FIFO SHALL succeed without setting overrun.
REQ-021 SHALL use FSM states S_WARM and S_RUN: S_WARM discards one full frame (filter settling), then moves to S_RUN; S_RUN pushes every frame.
REQ-022 SHALL, on restart, clear the accumulator and sample counter and enter S_WARM; the FIFO contents SHALL be kept; restart SHALL take priority over a sample arriving in the same cycle.
REQ-023 SHALL clear overrun on clr_overrun; if clr_overrun and a new overrun event occur in the same cycle, overrun SHALL remain set.
REQ-024 SHALL treat dec_log2=0 as pass-through (N=1), producing one result per valid sample in S_RUN.

Reset
REQ-025 SHALL, while n_RST=0, force out_data=0, out_valid=0 and overrun=0, clear the FIFO, accumulator and counter, and select S_WARM, all asynchronously.
REQ-026 SHALL, on a reset asserted mid-frame, discard the partial frame; the first output after reset SHALL come only after a warm frame plus a full frame.

Configuration
REQ-027 SHALL, with macro SAMPLE_DECIMATOR_ROUND_EN defined, add 2^(dec_log2-1) before the shift when dec_log2>0 (round half up); when the macro is undefined, the result SHALL be truncated (floor).

Structure
REQ-028 SHALL place the FSM state enum (S_WARM, S_RUN) and the FIFO depth constant (2) in the shared filter package.
REQ-029 SHALL implement the output buffer as sub-module dec_fifo2 (2-entry, valid/ready, full/empty flags).

Verification
REQ-030 SHALL test: dec_log2=2, in_valid=1, sig_in cycling 4,8,12,16 -> warm frame discarded, then out_data=10 every 4 cycles, out_valid one cycle after each 4th sample.
REQ-031 SHALL test: dec_log2=1, samples -1,-2 -> out_data=-2 without the macro; out_data=-1 with SAMPLE_DECIMATOR_ROUND_EN.
REQ-032 SHALL test: dec_log2=0, out_ready=0, samples 5,6,7 in S_RUN -> two results buffered, 7 dropped, overrun=1, out_data=5; then clr_overrun -> overrun=0.
REQ-033 SHALL test: n_RST pulsed low after 2 of 4 samples -> outputs 0 immediately; next out_valid only after 8 further valid samples.
REQ-034 SHALL test: dec_log2 changed 2->3 mid-frame -> current frame closes at 4 samples, next frame at 8; dec_log2=15 -> frame of 256 samples.
REQ-035 SHALL test: restart asserted with a valid sample in the same cycle -> sample ignored, S_WARM entered, buffered FIFO results still delivered.

Source files
------------

// File: rtl/sample_decimator_pkg.sv
// Shared definitions for the sample decimator: frame FSM states and output FIFO depth.
package sample_decimator_pkg;

  typedef enum logic {
    S_WARM = 1'b0,
    S_RUN  = 1'b1
  } dec_state_e;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/sample_decimator_fifo.sv
// dec_fifo2: two-entry result buffer with a valid/ready read side and full/empty flags.
module dec_fifo2
  import sample_decimator_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [W-1:0]  mem_q [FIFO_DEPTH];
  logic [W-1:0]  mem_d [FIFO_DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop, push_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(FIFO_DEPTH));
  assign data_o  = mem_q[0];
  assign pop     = !empty_o && ready_i;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
  assign push_ok = push_i && (!full_o || pop);

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mem_d = mem_q;
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
    end
    if (push_ok) mem_d[CW'(cnt_q - CW'(pop))] = data_i;
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
  end

  // NOTE: the storage is reset too, because the head entry drives out_data and must read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/sample_decimator.sv
// Averaging decimator: sums 2^dec_log2 samples per frame, shifts, buffers in dec_fifo2.
// Optional round-half-up before the shift with macro SAMPLE_DECIMATOR_ROUND_EN.
module sample_decimator
  import sample_decimator_pkg::*;
#(
  parameter int BITWIDTH     = 32,
  parameter int MAX_DEC_LOG2 = 8,
  parameter int DEC_WIDTH    = 4
) (
  input  logic                 clk,
  input  logic                 n_RST,
  input  logic [BITWIDTH-1:0]  sig_in,
  input  logic                 in_valid,
  input  logic [DEC_WIDTH-1:0] dec_log2,
  input  logic                 restart,
  output logic [BITWIDTH-1:0]  out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun,
  input  logic                 clr_overrun
);

  localparam int AW = BITWIDTH + MAX_DEC_LOG2;
  localparam int SW = $clog2(MAX_DEC_LOG2 + 1);
  localparam int CW = MAX_DEC_LOG2;

  dec_state_e    state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] shift_q, shift_d;
  logic          overrun_q, overrun_d;

  logic [SW-1:0]       dec_clamp, cur_shift;
  logic [CW-1:0]       last_idx;
  logic [AW-1:0]       sample_ext, sum, sum_r;
  logic [BITWIDTH-1:0] result;
  logic                sample_take, frame_done, frame_push, drop;
  logic                fifo_full, fifo_empty;

  assign dec_clamp = (32'(dec_log2) > MAX_DEC_LOG2) ? SW'(MAX_DEC_LOG2) : SW'(dec_log2);
  // The ratio is sampled on a frame's first sample; later samples use the latched copy.
  assign cur_shift   = (cnt_q == '0) ? dec_clamp : shift_q;
  assign last_idx    = ~({CW{1'b1}} << cur_shift);
  assign sample_take = in_valid && !restart;
  assign frame_done  = sample_take && (cnt_q == last_idx);

  assign sample_ext = {{MAX_DEC_LOG2{sig_in[BITWIDTH-1]}}, sig_in};
  assign sum        = acc_q + sample_ext;
`ifdef SAMPLE_DECIMATOR_ROUND_EN
  assign sum_r = (cur_shift != '0) ? sum + (AW'(1) << (cur_shift - SW'(1))) : sum;
`else
  assign sum_r = sum;
`endif
  assign result = BITWIDTH'($signed(sum_r) >>> cur_shift);

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (restart) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (sample_take) begin
      if (cnt_q == '0) shift_d = dec_clamp;
      if (frame_done) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) state_q <= S_WARM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (restart)                               state_d = S_WARM;
    else if (frame_done && state_q == S_WARM)  state_d = S_RUN;
  end

  always_comb begin
    frame_push = 1'b0;
    if (state_q == S_RUN && frame_done) frame_push = 1'b1;
  end

  dec_fifo2 #(.W(BITWIDTH)) u_fifo (
    .clk     (clk),
    .rst_n   (n_RST),
    .push_i  (frame_push),
    .data_i  (result),
    .ready_i (out_ready),
    .data_o  (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign drop      = frame_push && fifo_full && !(out_valid && out_ready);
  // A drop in the same cycle as a clear wins, so no overrun event is lost.
  assign overrun_d = drop || (overrun_q && !clr_overrun);
  assign overrun   = overrun_q;

  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_sample_decimator.sv
// Scoreboard bench for sample_decimator: a frame-level reference model queues expected
// results at stimulus time; a negedge monitor pops and compares on every transfer.
module tb_sample_decimator;

  localparam int BW = 32;
  localparam int ML = 8;
  localparam int DW = 4;
  localparam int FD = 2;
`ifdef SAMPLE_DECIMATOR_ROUND_EN
  localparam int EXP031 = -1;
`else
  localparam int EXP031 = -2;
`endif

  logic          clk = 1'b0;
  logic          n_rst, in_valid, restart, out_ready, clr_overrun;
  logic [BW-1:0] sig_in, out_data;
  logic [DW-1:0] dec_log2;
  logic          out_valid, overrun;

  int checks = 0;
  int errors = 0;

  int exp_q[$];
  int m_frame[$];
  int m_occ   = 0;
  int m_shift = 0;
  bit m_ov    = 1'b0;
  bit m_warm  = 1'b1;

  sample_decimator #(.BITWIDTH(BW), .MAX_DEC_LOG2(ML), .DEC_WIDTH(DW)) dut (
    .clk         (clk),
    .n_RST       (n_rst),
    .sig_in      (sig_in),
    .in_valid    (in_valid),
    .dec_log2    (dec_log2),
    .restart     (restart),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame average from the collected samples: floor (or round-half-up) division by N.
  function automatic int frame_result(int sh);
    longint sum = 0;
    longint n   = longint'(1) << sh;
    longint q;
    foreach (m_frame[i]) sum += longint'(m_frame[i]);
`ifdef SAMPLE_DECIMATOR_ROUND_EN
    if (sh > 0) sum += n / 2;
`endif
    q = sum / n;
    if ((sum % n) != 0 && sum < 0) q -= 1;
    return int'(q);
  endfunction

  task automatic step(input bit v, input int s, input bit rdy, input int dec,
                      input bit rs = 1'b0, input bit clr = 1'b0);
    bit pop, push, drop;
    int res = 0;
    in_valid    = v;
    sig_in      = s;
    out_ready   = rdy;
    dec_log2    = DW'(dec);
    restart     = rs;
    clr_overrun = clr;
    pop  = (m_occ > 0) && rdy;
    push = 1'b0;
    if (rs) begin
      m_frame.delete();
      m_warm = 1'b1;
    end else if (v) begin
      if (m_frame.size() == 0) m_shift = (dec > ML) ? ML : dec;
      m_frame.push_back(s);
      if (m_frame.size() == (1 << m_shift)) begin
        res = frame_result(m_shift);
        if (m_warm) m_warm = 1'b0;
        else        push   = 1'b1;
        m_frame.delete();
      end
    end
    drop = push && (m_occ == FD) && !pop;
    if (push && !drop) exp_q.push_back(res);
    m_occ += int'(push && !drop) - int'(pop);
    m_ov = drop || (m_ov && !clr);
    @(posedge clk);
    #1;
    check("valid", out_valid, m_occ > 0);
    check("overrun", overrun, m_ov);
    if (m_occ > 0) check("head_data", $signed(out_data), exp_q[0]);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", $signed(out_data), 0);
    check("rst_overrun", overrun, 0);
    exp_q.delete();
    m_frame.delete();
    m_occ  = 0;
    m_ov   = 1'b0;
    m_warm = 1'b1;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (n_rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_spurious: got out_data %0d, expected no transfer (t=%0t)",
                 $signed(out_data), $time);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("mon_data", $signed(out_data), e);
      end
    end
  end

  initial begin
    n_rst = 1'b0; in_valid = 1'b0; restart = 1'b0; out_ready = 1'b0;
    clr_overrun = 1'b0; sig_in = '0; dec_log2 = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Warm frame discarded, then 10 one cycle after every 4th sample.
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < 4; j++) begin
        step(1'b1, 4 * (j + 1), 1'b1, 2);
        if (j == 3 && f == 0) check("r030_warm", out_valid, 0);
        if (j == 3 && f > 0) begin
          check("r030_valid", out_valid, 1);
          check("r030_data", $signed(out_data), 10);
        end
      end
    end

    step(1'b0, 0, 1'b1, 1);
    step(1'b1, -1, 1'b0, 1);
    step(1'b1, -2, 1'b0, 1);
    check("r031_data", $signed(out_data), EXP031);
    step(1'b0, 0, 1'b1, 1);

    // Pass-through with a stalled consumer: third result dropped.
    step(1'b1, 5, 1'b0, 0);
    step(1'b1, 6, 1'b0, 0);
    step(1'b1, 7, 1'b0, 0);
    check("r032_data", $signed(out_data), 5);
    check("r032_overrun", overrun, 1);
    step(1'b1, 8, 1'b0, 0, 1'b0, 1'b1);
    check("r023_clr_race", overrun, 1);
    step(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    check("r032_cleared", overrun, 0);
    step(1'b1, 9, 1'b1, 0);
    check("r020_full_popush", overrun, 0);

    // Reset mid-frame with results still buffered.
    step(1'b1, 1, 1'b0, 2);
    step(1'b1, 2, 1'b0, 2);
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 0, 1'b1, 2);
      step(1'b1, k * 3, 1'b1, 2);
      if (k == 7) check("r033_early", out_valid, 0);
      if (k == 8) check("r033_first", out_valid, 1);
    end

    // Ratio change mid-frame applies to the next frame; oversize ratio clamps to 256.
    step(1'b1, 10, 1'b1, 2);
    step(1'b1, 10, 1'b1, 2);
    step(1'b1, 10, 1'b1, 3);
    step(1'b1, 10, 1'b1, 3);
    check("r034_close4", out_valid, 1);
    check("r034_data4", $signed(out_data), 10);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, int'($urandom_range(0, 1000)) - 500, 1'b1, 3);
      if (k == 7) check("r034_open8", out_valid, 0);
      if (k == 8) check("r034_close8", out_valid, 1);
    end
    for (int k = 1; k <= 256; k++) begin
      step(1'b1, int'($urandom), 1'b1, 15);
      if (k == 255) check("r034_open256", out_valid, 0);
      if (k == 256) check("r034_close256", out_valid, 1);
    end

    // Restart with a coincident sample keeps buffered results.
    step(1'b1, 100, 1'b1, 0);
    step(1'b1, 200, 1'b0, 0);
    step(1'b1, 300, 1'b0, 0, 1'b1);
    check("r035_keep_valid", out_valid, 1);
    check("r035_keep_data", $signed(out_data), 100);
    step(1'b1, 400, 1'b1, 0);
    step(1'b1, 500, 1'b1, 0);
    step(1'b0, 0, 1'b1, 0);

    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(0, 3) != 0, int'($urandom), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), $urandom_range(0, 63) == 0,
           $urandom_range(0, 15) == 0);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 0, 1'b1, 0);
    check("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
